// File: rtl/la_pkg.sv
// Shared types and constants for the trigger qualification logic.
package la_pkg;

  typedef enum logic [1:0] {
    RISING    = 2'd0,
    FALLING   = 2'd1,
    EITHER    = 2'd2,
    IMMEDIATE = 2'd3
  } trig_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIRED = 2'd3
  } trig_state_t;

  localparam int unsigned RESET_LEVEL = 32'h80;
  localparam logic [1:0]  MODE_RISING    = 2'd0;
  localparam logic [1:0]  MODE_FALLING   = 2'd1;
  localparam logic [1:0]  MODE_EITHER    = 2'd2;
  localparam logic [1:0]  MODE_IMMEDIATE = 2'd3;

endpackage

// File: rtl/trig_threshold.sv
// Saturating hysteresis band around the trigger level: lo = level-hyst, hi = level+hyst,
// both clamped to the unsigned DATA_W range.
module trig_threshold #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] level,
  input  logic [DATA_W-1:0] hyst,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum = {1'b0, level} + {1'b0, hyst};
    lo  = (hyst > level) ? '0 : level - hyst;
    hi  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  end

endmodule

// File: rtl/trigger_detect.sv
// ADC trigger qualifier: 2-stage sample pipeline, level/hysteresis search FSM, registered trig.
// Optional auto-trigger timeout is enabled by defining TRIGGER_TIMEOUT_EN (adds timed_out).
module trigger_detect
  import la_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef TRIGGER_TIMEOUT_EN
  , parameter int TIMEOUT_W = 24
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cfg_level,
  input  logic [DATA_W-1:0] cfg_hyst,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              trig,
  output logic              triggered,
  output logic              armed
`ifdef TRIGGER_TIMEOUT_EN
  , output logic            timed_out
`endif
);

  logic [DATA_W-1:0] s1, s2;
  logic [DATA_W-1:0] level_q, hyst_q, lo, hi;
  trig_mode_t        mode_q;
  trig_state_t       state, state_d;
  logic              dir_fall, dir_fall_d;
  logic              fire;
  logic              tmo_hit;

  trig_threshold #(.DATA_W(DATA_W)) u_threshold (
    .level (level_q),
    .hyst  (hyst_q),
    .lo    (lo),
    .hi    (hi)
  );

`ifdef TRIGGER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  assign tmo_hit = ((state == ST_PRIME) || (state == ST_WAIT)) && (&tmo_cnt);
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state;
    dir_fall_d = dir_fall;
    fire       = 1'b0;
    unique case (state)
      ST_IDLE: if (arm) state_d = ST_PRIME;
      ST_PRIME: begin
        unique case (mode_q)
          RISING:    if (s1 <= lo) begin state_d = ST_WAIT; dir_fall_d = 1'b0; end
          FALLING:   if (s1 >= hi) begin state_d = ST_WAIT; dir_fall_d = 1'b1; end
          EITHER: begin
            if (s1 <= lo) begin
              state_d    = ST_WAIT;
              dir_fall_d = 1'b0;
            end else if (s1 >= hi) begin
              state_d    = ST_WAIT;
              dir_fall_d = 1'b1;
            end
          end
          IMMEDIATE: fire = 1'b1;
        endcase
      end
      ST_WAIT:  fire = dir_fall ? (s1 <= level_q) : (s1 >= level_q);
      ST_FIRED: ;
    endcase
    if (tmo_hit) fire = 1'b1;
    if (fire) state_d = ST_FIRED;
    // Dropping arm wins over everything, including a fire decided this cycle.
    if (!arm) begin
      state_d = ST_IDLE;
      fire    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      state    <= ST_IDLE;
      dir_fall <= 1'b0;
      trig     <= 1'b0;
      // NOTE: config registers are reset to usable defaults so an arm without cfg_valid is well defined.
      level_q  <= DATA_W'(RESET_LEVEL);
      hyst_q   <= '0;
      mode_q   <= RISING;
    end else begin
      s1       <= adc_data;
      s2       <= s1;
      state    <= state_d;
      dir_fall <= dir_fall_d;
      trig     <= fire;
      if ((state == ST_IDLE) && cfg_valid) begin
        level_q <= cfg_level;
        hyst_q  <= cfg_hyst;
        mode_q  <= trig_mode_t'(cfg_mode);
      end
    end
  end

`ifdef TRIGGER_TIMEOUT_EN
  // Counter holds zero outside the search so it is cleared on entry to PRIME.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      if ((state == ST_PRIME) || (state == ST_WAIT)) tmo_cnt <= tmo_cnt + 1'b1;
      else                                           tmo_cnt <= '0;
      timed_out <= (state_d == ST_FIRED) && (timed_out || tmo_hit);
    end
  end
`endif

  assign sample_out = s2;
  assign triggered  = (state == ST_FIRED);
  assign armed      = (state == ST_PRIME) || (state == ST_WAIT);

endmodule
